// File: rtl/parity_check_serial_pkg.sv
// Shared types, constants and parity helper for the serial UART parity checker.
package parity_check_serial_pkg;

    localparam int unsigned MIN_DATA_WIDTH = 5;
    localparam int unsigned WIDTH_W        = 4;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_mode_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Parity bit the receiver should see; inject flips it to force a mismatch.
    function automatic logic expected_parity(input logic acc, input parity_mode_t mode,
                                             input logic inject);
        logic exp_p;
        case (mode)
            PAR_EVEN: exp_p = acc;
            PAR_ODD:  exp_p = ~acc;
            PAR_MARK: exp_p = 1'b1;
            default:  exp_p = 1'b0;
        endcase
        return exp_p ^ inject;
    endfunction

endpackage

// File: rtl/parity_check_serial_err_counter.sv
// Saturating parity-error counter; a clear in the same cycle as an increment leaves it at 1.
module parity_err_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = clear_i ? '0 : count_q;
        if (inc_i && (count_d != '1)) begin
            count_d = count_d + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/parity_check_serial.sv
// Serial UART RX parity checker: accumulates data-bit parity and checks the parity bit.
// PARITY_ERR_COUNT_EN builds the saturating error counter; otherwise err_count is tied to 0.
module parity_check_serial
    import parity_check_serial_pkg::*;
#(
    parameter int unsigned MAX_DATA_WIDTH = 9,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               data_width,
    input  logic [2:0]               parity_mode,
    input  logic                     frame_start,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     parity_fault_injection,
    input  logic                     clear_err,
    output logic                     busy,
    output logic                     check_valid,
    output logic                     PARITYERR,
    output logic                     parity_err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    state_t               state_q, state_d;
    parity_mode_t         mode_q, mode_d, mode_in;
    logic [WIDTH_W-1:0]   width_q, width_d, width_clamped;
    logic [WIDTH_W-1:0]   cnt_q, cnt_d;
    logic                 acc_q, acc_d;
    logic                 err_d;
    logic                 done_d;
    logic                 busy_q, busy_d;
    logic                 check_valid_q, check_valid_d;
    logic                 perr_q, perr_d;
    logic                 sticky_q, sticky_d;

    // Clamp the requested width into the supported range.
    always_comb begin
        width_clamped = data_width;
        if (data_width < WIDTH_W'(MIN_DATA_WIDTH)) begin
            width_clamped = WIDTH_W'(MIN_DATA_WIDTH);
        end else if (data_width > WIDTH_W'(MAX_DATA_WIDTH)) begin
            width_clamped = WIDTH_W'(MAX_DATA_WIDTH);
        end
    end

    assign mode_in = (parity_mode <= 3'd4) ? parity_mode_t'(parity_mode) : PAR_NONE;

    // Frame sequencing; frame_start restarts from any state.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        if (frame_start) begin
            mode_d  = mode_in;
            width_d = width_clamped;
            cnt_d   = '0;
            acc_d   = 1'b0;
            state_d = S_DATA;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_DATA: begin
                    if (bit_valid) begin
                        acc_d = acc_q ^ bit_in;
                        cnt_d = cnt_q + WIDTH_W'(1);
                        if (cnt_d == width_q) begin
                            state_d = (mode_q == PAR_NONE) ? S_DONE : S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_valid) begin
                        err_d   = bit_in != expected_parity(acc_q, mode_q, parity_fault_injection);
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        done_d        = (state_d == S_DONE) && (state_q != S_DONE);
        busy_d        = (state_d == S_DATA) || (state_d == S_PARITY);
        check_valid_d = done_d;
        perr_d        = done_d ? err_d : perr_q;
        sticky_d      = (clear_err ? 1'b0 : sticky_q) | (done_d & err_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mode_q        <= PAR_NONE;
            width_q       <= '0;
            cnt_q         <= '0;
            acc_q         <= 1'b0;
            busy_q        <= 1'b0;
            check_valid_q <= 1'b0;
            perr_q        <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            width_q       <= width_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            busy_q        <= busy_d;
            check_valid_q <= check_valid_d;
            perr_q        <= perr_d;
            sticky_q      <= sticky_d;
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    parity_err_counter #(
        .WIDTH(ERR_CNT_WIDTH)
    ) u_err_counter (
        .clk    (clk),
        .reset  (reset),
        .clear_i(clear_err),
        .inc_i  (done_d & err_d),
        .count_o(err_count)
    );
`else
    assign err_count = '0;
`endif

    assign busy              = busy_q;
    assign check_valid       = check_valid_q;
    assign PARITYERR         = perr_q;
    assign parity_err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_check_serial.sv
// Directed + randomized bench for parity_check_serial against a popcount-based frame model.
module tb_parity_check_serial;

    localparam int unsigned MAXW = 9;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    data_width;
    logic [2:0]    parity_mode;
    logic          frame_start;
    logic          bit_valid;
    logic          bit_in;
    logic          parity_fault_injection;
    logic          clear_err;
    logic          busy;
    logic          check_valid;
    logic          PARITYERR;
    logic          parity_err_sticky;
    logic [CW-1:0] err_count;

    int total = 0;
    int bad   = 0;
    bit sticky_m;
    int count_m;

    parity_check_serial #(
        .MAX_DATA_WIDTH(MAXW),
        .ERR_CNT_WIDTH (CW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .data_width            (data_width),
        .parity_mode           (parity_mode),
        .frame_start           (frame_start),
        .bit_valid             (bit_valid),
        .bit_in                (bit_in),
        .parity_fault_injection(parity_fault_injection),
        .clear_err             (clear_err),
        .busy                  (busy),
        .check_valid           (check_valid),
        .PARITYERR             (PARITYERR),
        .parity_err_sticky     (parity_err_sticky),
        .err_count             (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_count();
`ifdef PARITY_ERR_COUNT_EN
        return count_m;
`else
        return 0;
`endif
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, ".sticky"}, 32'(parity_err_sticky), 32'(sticky_m));
        chk({tag, ".count"}, 32'(err_count), 32'(exp_count()));
    endtask

    task automatic send_frame(input string tag, input int w, input int m, input logic [15:0] data,
                              input logic pbit, input logic inj, input logic clr,
                              input bit gaps);
        int ew;
        int ones;
        int exp_p;
        bit none;
        bit err;
        ew   = (w < 5) ? 5 : ((w > int'(MAXW)) ? int'(MAXW) : w);
        none = (m == 0) || (m > 4);
        ones = 0;
        for (int i = 0; i < ew; i++) ones += int'(data[i]);
        case (m)
            1:       exp_p = ones % 2;
            2:       exp_p = 1 - (ones % 2);
            3:       exp_p = 1;
            default: exp_p = 0;
        endcase
        if (inj) exp_p = 1 - exp_p;
        err = !none && (int'(pbit) != exp_p);

        frame_start = 1'b1;
        data_width  = 4'(w);
        parity_mode = 3'(m);
        bit_valid   = 1'(($urandom % 2));
        bit_in      = 1'(($urandom % 2));
        tick();
        frame_start = 1'b0;
        data_width  = 4'($urandom);
        parity_mode = 3'($urandom);
        bit_valid   = 1'b0;
        chk({tag, ".busy_start"}, 32'(busy), 32'd1);
        chk({tag, ".cv_start"}, 32'(check_valid), 32'd0);

        for (int i = 0; i < ew; i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                bit_in = 1'(($urandom % 2));
                tick();
                chk({tag, ".cv_gap"}, 32'(check_valid), 32'd0);
            end
            bit_valid = 1'b1;
            bit_in    = data[i];
            if (none && i == ew - 1) clear_err = clr;
            tick();
            bit_valid = 1'b0;
            clear_err = 1'b0;
            if (!(none && i == ew - 1)) begin
                chk({tag, ".busy_data"}, 32'(busy), 32'd1);
                chk({tag, ".cv_data"}, 32'(check_valid), 32'd0);
            end
        end

        if (!none) begin
            if (gaps && ($urandom % 2 == 0)) begin
                tick();
                chk({tag, ".cv_pgap"}, 32'(check_valid), 32'd0);
            end
            bit_valid              = 1'b1;
            bit_in                 = pbit;
            parity_fault_injection = inj;
            clear_err              = clr;
            tick();
            bit_valid              = 1'b0;
            parity_fault_injection = 1'b0;
            clear_err              = 1'b0;
        end

        if (clr) begin
            sticky_m = 1'b0;
            count_m  = 0;
        end
        if (err) begin
            sticky_m = 1'b1;
            if (count_m < CMAX) count_m++;
        end
        chk({tag, ".cv"}, 32'(check_valid), 32'd1);
        chk({tag, ".perr"}, 32'(PARITYERR), 32'(err));
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        check_flags(tag);
        tick();
        chk({tag, ".cv_after"}, 32'(check_valid), 32'd0);
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        check_flags({tag, ".after"});
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".cv"}, 32'(check_valid), 32'd0);
        chk({tag, ".perr"}, 32'(PARITYERR), 32'd0);
        chk({tag, ".sticky"}, 32'(parity_err_sticky), 32'd0);
        chk({tag, ".count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        reset                  = 1'b1;
        data_width             = 4'd0;
        parity_mode            = 3'd0;
        frame_start            = 1'b0;
        bit_valid              = 1'b0;
        bit_in                 = 1'b0;
        parity_fault_injection = 1'b0;
        clear_err              = 1'b0;
        sticky_m               = 1'b0;
        count_m                = 0;
        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b0;

        // bit_valid in IDLE is ignored
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        tick();
        bit_valid = 1'b0;
        chk("idle_bits.busy", 32'(busy), 32'd0);
        chk("idle_bits.cv", 32'(check_valid), 32'd0);

        send_frame("even_5a", 8, 1, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame("odd_03", 7, 2, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame("odd_03b", 7, 2, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame("clr_err", 7, 2, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_err.count1", 32'(err_count), 32'(exp_count()));

        send_frame("none_w5", 5, 0, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame("none_w3", 3, 0, 16'h001F, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame("none_w12", 12, 7, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame("even_w12", 12, 1, 16'h0E01, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame("mark_inj", 6, 3, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame("space_ok", 6, 4, 16'h003F, 1'b0, 1'b0, 1'b0, 1'b0);

        // standalone clear
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        sticky_m  = 1'b0;
        count_m   = 0;
        check_flags("clear");

        for (int k = 0; k < 5; k++) begin
            send_frame("sat", 5, 3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat.final", 32'(err_count), 32'(exp_count()));
        chk("sticky.set", 32'(parity_err_sticky), 32'd1);

        // abort after 4 bits, then reset mid-frame; neither frame checks
        frame_start = 1'b1;
        data_width  = 4'd8;
        parity_mode = 3'd1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'(i % 2);
            tick();
            chk("abort.cv", 32'(check_valid), 32'd0);
        end
        frame_start = 1'b1;
        data_width  = 4'd5;
        parity_mode = 3'd0;
        bit_valid   = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("restart.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("restart.cv", 32'(check_valid), 32'd0);
        end
        reset = 1'b1;
        tick();
        bit_valid = 1'b0;
        check_reset_values("midreset");
        reset    = 1'b0;
        sticky_m = 1'b0;
        count_m  = 0;
        tick();
        chk("postreset.cv", 32'(check_valid), 32'd0);

        for (int k = 0; k < 40; k++) begin
            send_frame("rand", int'($urandom % 16), int'($urandom % 8), 16'($urandom),
                       1'(($urandom % 2)), 1'(($urandom % 2)), 1'(($urandom % 5 == 0)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_check_serial.md
Name: parity_check_serial

Overview:
- Sequential, parametrised successor to the combinational UART parity checker; sits in the UART RX path between the bit sampler and the RX FIFO.
- Accumulates parity serially over a frame of 5..MAX_DATA_WIDTH data bits, then checks the received parity bit.
- Supports five parity modes, fault injection, a sticky error flag and a saturating error counter.

Parameters:
- MAX_DATA_WIDTH, 9: largest supported data field in bits (legal 5..15).
- ERR_CNT_WIDTH, 8: width of the parity error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_width  in  4  data bits per frame; sampled on frame_start
- parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 treated as none; sampled on frame_start
- frame_start  in  1  one-cycle strobe; start of a new frame
- bit_valid  in  1  qualifies bit_in (one strobe per sampled bit, LSB first)
- bit_in  in  1  sampled serial bit
- parity_fault_injection  in  1  when high at parity-bit acceptance, the expected parity is inverted
- clear_err  in  1  clears parity_err_sticky and err_count
- busy  out  1  frame in progress
- check_valid  out  1  one-cycle pulse; frame check complete
- PARITYERR  out  1  valid only with check_valid; 1 = parity mismatch
- parity_err_sticky  out  1  set on any PARITYERR, held until clear_err
- err_count  out  ERR_CNT_WIDTH  count of PARITYERR events, saturating

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. It overrides all other inputs and wins mid-frame.
- Reset values: state IDLE; busy, check_valid, PARITYERR, parity_err_sticky all 0; err_count 0; accumulator and bit counter 0.
- FSM states: IDLE, DATA, PARITY, DONE.
- IDLE:
  - On frame_start: latch the clamped width and the mode, clear accumulator and counter, go to DATA.
  - Width clamp: values below 5 become 5; values above MAX_DATA_WIDTH become MAX_DATA_WIDTH.
  - bit_valid in IDLE, including the cycle of frame_start, is ignored.
- DATA:
  - Each bit_valid: accumulator ^= bit_in, counter++.
  - On acceptance of the last data bit, go to DONE if mode is none, otherwise to PARITY.
- PARITY: next bit_valid is the parity bit; go to DONE.
  - Expected parity: even = acc; odd = ~acc; mark = 1; space = 0.
  - If parity_fault_injection is high that cycle, expected is inverted.
  - err = (bit_in != expected). Mode none: err = 0.
- DONE: lasts exactly one cycle. check_valid = 1 and PARITYERR = err (registered outputs), then go to IDLE.
- Latency: check_valid asserts the cycle after the final accepted bit (parity bit, or last data bit in mode none).
- busy = 1 in DATA and PARITY; 0 in IDLE and DONE.
- frame_start while busy or in DONE: the current frame is aborted with no check_valid, and a new frame starts exactly as from IDLE. The same-cycle bit_valid is ignored.
- parity_err_sticky: set on the DONE cycle when err = 1.
- err_count: increments on the DONE cycle when err = 1; saturates at all-ones.
- clear_err in the same cycle as an error: clear first, then apply the event. Result is sticky = 1, err_count = 1.
- Outputs are only updated at the points above; all other outputs are held between events.

Optional Feature:
- Macro: PARITY_ERR_COUNT_EN.
- Defined: err_count is implemented as specified.
- Undefined: no counter register; err_count is tied to 0. parity_err_sticky and PARITYERR are unaffected.

Decomposition:
- Package parity_check_serial_pkg holds:
  - parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE)
  - state_t enum (S_IDLE, S_DATA, S_PARITY, S_DONE)
  - constant MIN_DATA_WIDTH = 5
  - function expected_parity(acc, mode, inject)
- One sub-module is natural: parity_err_counter (saturating counter with synchronous clear and increment; clear-then-increment priority), instantiated under PARITY_ERR_COUNT_EN.

Test Plan:
- Even, width 8, data 0x5A (LSB first), parity bit 0 -> check_valid one cycle after the parity bit, PARITYERR = 0, err_count = 0.
- Odd, width 7, data 0x03, parity bit 0 -> PARITYERR = 1, sticky = 1, err_count = 1. Then clear_err plus a simultaneous new error -> sticky = 1, err_count = 1.
- Mode none, width 5, 5 bits -> check_valid the cycle after bit 5, PARITYERR = 0, no parity bit consumed. data_width = 3 behaves as 5; data_width = 12 with MAX 9 behaves as 9.
- Mark mode with parity bit 1 and parity_fault_injection = 1 -> PARITYERR = 1. Space mode with parity bit 0 and no injection -> PARITYERR = 0.
- Frame aborted after 4 bits by frame_start, then reset asserted mid-frame on the next frame -> no check_valid from either; all outputs return to reset values the cycle after reset.
- ERR_CNT_WIDTH = 2, five erroneous frames -> err_count = 3, holding. With PARITY_ERR_COUNT_EN undefined -> err_count stays 0 while sticky sets.
